// File: rtl/march_bist_pkg.sv
// march_bist_pkg: shared encodings, march element tables and FSM state type
//   op_t    : bit1 = write, bit0 = data is ~Background ("1")
//   elem_t  : one march element (direction, op count, first and second op)
//   elem_of : element table lookup, mode 0 = March C-, mode 1 = MATS+
package march_bist_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef logic [1:0] op_t;
    localparam op_t OP_R0 = 2'b00;
    localparam op_t OP_R1 = 2'b01;
    localparam op_t OP_W0 = 2'b10;
    localparam op_t OP_W1 = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef logic [2:0] elem_idx_t;
    localparam elem_idx_t N_ELEM_C = 3'd6;
    localparam elem_idx_t N_ELEM_M = 3'd3;

    typedef struct packed {
        logic dir;
        logic two;
        op_t  op0;
        op_t  op1;
    } elem_t;

    function automatic logic elem_dn(input logic mode, input elem_idx_t idx);
        return mode ? idx == 3'd2 : (idx == 3'd3 || idx == 3'd4);
    endfunction

    function automatic elem_t elem_of(input logic mode, input elem_idx_t idx);
        elem_t e;
        e.dir = elem_dn(mode, idx) ? DIR_DN : DIR_UP;
        case ({mode, idx})
            4'b0_000, 4'b1_000: {e.two, e.op0, e.op1} = {1'b0, OP_W0, OP_W0};
            4'b0_001, 4'b1_001: {e.two, e.op0, e.op1} = {1'b1, OP_R0, OP_W1};
            4'b0_010, 4'b1_010: {e.two, e.op0, e.op1} = {1'b1, OP_R1, OP_W0};
            4'b0_011:           {e.two, e.op0, e.op1} = {1'b1, OP_R0, OP_W1};
            4'b0_100:           {e.two, e.op0, e.op1} = {1'b1, OP_R1, OP_W0};
            default:            {e.two, e.op0, e.op1} = {1'b0, OP_R0, OP_R0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/march_bist_if.sv
// march_bist_if: single-port SRAM bus between the BIST engine and the memory
//   Sram_Addr/Sram_En/Sram_WE/Sram_Wdata : engine -> SRAM
//   Sram_Rdata                           : SRAM -> engine, RD_LAT cycles after a read
interface march_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] Sram_Addr;
    logic              Sram_En;
    logic              Sram_WE;
    logic [DATA_W-1:0] Sram_Wdata;
    logic [DATA_W-1:0] Sram_Rdata;

    modport master (output Sram_Addr, Sram_En, Sram_WE, Sram_Wdata, input Sram_Rdata);
    modport slave  (input Sram_Addr, Sram_En, Sram_WE, Sram_Wdata, output Sram_Rdata);
endinterface

// File: rtl/march_bist_cmp.sv
// march_bist_cmp: read-tag delay line, comparator, fail counter and first-fail capture
//   clr                          : clears results and delay line (accepted Start)
//   in_v/in_exp/in_addr/in_elem  : tag of the read presented to the SRAM this cycle
//   rdata                        : SRAM read data
//   hit                          : combinational miscompare this cycle
//   fail/fail_count/ff_*         : sticky flag, saturating count, first-fail capture
module march_bist_cmp
    import march_bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 12
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              clr,
    input  logic              in_v,
    input  logic [DATA_W-1:0] in_exp,
    input  logic [ADDR_W-1:0] in_addr,
    input  elem_idx_t         in_elem,
    input  logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] ff_addr,
    output elem_idx_t         ff_elem,
    output logic [DATA_W-1:0] ff_syn
);
    localparam int TW = 1 + DATA_W + ADDR_W + 3;

    logic [TW-1:0]     dl [RD_LAT];
    logic              o_v;
    logic [DATA_W-1:0] o_exp;
    logic [ADDR_W-1:0] o_addr;
    elem_idx_t         o_elem;

    // the tag leaves the line in the same cycle its read data is valid
    assign {o_v, o_exp, o_addr, o_elem} = dl[RD_LAT-1];
    assign hit = o_v && (o_exp != rdata);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
            fail       <= 1'b0;
            fail_count <= '0;
            ff_addr    <= '0;
            ff_elem    <= '0;
            ff_syn     <= '0;
        end else begin
            dl[0] <= clr ? '0 : {in_v, in_exp, in_addr, in_elem};
            for (int i = 1; i < RD_LAT; i++) dl[i] <= clr ? '0 : dl[i-1];
            if (clr) begin
                fail       <= 1'b0;
                fail_count <= '0;
                ff_addr    <= '0;
                ff_elem    <= '0;
                ff_syn     <= '0;
            end else if (hit) begin
                fail       <= 1'b1;
                fail_count <= fail_count + {{(CNT_W-1){1'b0}}, ~&fail_count};
                if (!fail) begin
                    ff_addr <= o_addr;
                    ff_elem <= o_elem;
                    ff_syn  <= o_exp ^ rdata;
                end
            end
        end
    end
endmodule

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- / MATS+ BIST engine for one 2**ADDR_W x DATA_W single-port SRAM
//   Clock, Reset_n (async, active low)
//   Start/Mode/Background : run request, algorithm select, data background (sampled in IDLE/DONE)
//   sram                  : SRAM bus (master side)
//   Busy/Done/Pass/Fail   : run status; Done held until the next accepted Start
//   Fail_Count, First_Fail_Addr/Elem/Syn : fail statistics and first-fail capture
module march_bist_ctrl
    import march_bist_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 4,
    parameter int RD_LAT       = 1,
    parameter int CNT_W        = 12,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Mode,
    input  logic [DATA_W-1:0] Background,
    march_bist_if.master      sram,
    output logic              Busy,
    output logic              Done,
    output logic              Fail,
    output logic              Pass,
    output logic [CNT_W-1:0]  Fail_Count,
    output logic [ADDR_W-1:0] First_Fail_Addr,
    output elem_idx_t         First_Fail_Elem,
    output logic [DATA_W-1:0] First_Fail_Syn
);
    localparam int DW = $clog2(RD_LAT + 1);

    state_t            state;
    logic              mode_q;
    logic [DATA_W-1:0] bg_q;
    elem_idx_t         elem;
    elem_idx_t         elem_q;
    logic [ADDR_W-1:0] addr;
    logic              opi;
    logic [DW-1:0]     drain;
    elem_t             cur;
    op_t               op;
    logic              last_op, last_addr, last_elem, nxt_dn, hit, stop, start_ok;

    assign cur       = elem_of(mode_q, elem);
    assign op        = opi ? cur.op1 : cur.op0;
    assign last_op   = ~cur.two | opi;
    assign last_addr = cur.dir == DIR_DN ? ~|addr : &addr;
    assign last_elem = elem == (mode_q ? N_ELEM_M : N_ELEM_C) - 3'd1;
    assign nxt_dn    = elem_dn(mode_q, elem + 3'd1);
    assign stop      = (STOP_ON_FAIL != 0) && hit;
    assign start_ok  = Start && (state == S_IDLE || state == S_DONE);
    assign Pass      = Done & ~Fail;

    // SRAM outputs are registered: the op sequenced in cycle n appears after edge n,
    // so the first op of a run is on the bus after edge k+1
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= S_IDLE;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            mode_q          <= 1'b0;
            bg_q            <= '0;
            elem            <= '0;
            elem_q          <= '0;
            addr            <= '0;
            opi             <= 1'b0;
            drain           <= '0;
            sram.Sram_En    <= 1'b0;
            sram.Sram_WE    <= 1'b0;
            sram.Sram_Addr  <= '0;
            sram.Sram_Wdata <= '0;
        end else begin
            sram.Sram_En <= 1'b0;
            sram.Sram_WE <= 1'b0;
            case (state)
                S_IDLE, S_DONE: if (Start) begin
                    state  <= S_RUN;
                    Busy   <= 1'b1;
                    Done   <= 1'b0;
                    mode_q <= Mode;
                    bg_q   <= Background;
                    elem   <= '0;
                    addr   <= '0;
                    opi    <= 1'b0;
                end
                S_RUN: if (stop) begin
                    state <= S_DRAIN;
                    drain <= '0;
                end else begin
                    sram.Sram_En    <= 1'b1;
                    sram.Sram_WE    <= op[1];
                    sram.Sram_Addr  <= addr;
                    sram.Sram_Wdata <= op[0] ? ~bg_q : bg_q;
                    elem_q          <= elem;
                    opi             <= ~last_op;
                    if (last_op) begin
                        if (!last_addr) addr <= cur.dir == DIR_DN ? addr - 1'b1 : addr + 1'b1;
                        else if (!last_elem) begin
                            elem <= elem + 3'd1;
                            addr <= nxt_dn ? '1 : '0;
                        end else begin
                            state <= S_DRAIN;
                            drain <= '0;
                        end
                    end
                end
                // one extra cycle beyond RD_LAT lets the last read reach the comparator
                S_DRAIN: if (drain == DW'(RD_LAT)) begin
                    state <= S_DONE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end else drain <= drain + 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

    march_bist_cmp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT),
        .CNT_W (CNT_W)
    ) u_cmp (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .clr       (start_ok),
        .in_v      (sram.Sram_En & ~sram.Sram_WE),
        .in_exp    (sram.Sram_Wdata),
        .in_addr   (sram.Sram_Addr),
        .in_elem   (elem_q),
        .rdata     (sram.Sram_Rdata),
        .hit       (hit),
        .fail      (Fail),
        .fail_count(Fail_Count),
        .ff_addr   (First_Fail_Addr),
        .ff_elem   (First_Fail_Elem),
        .ff_syn    (First_Fail_Syn)
    );
endmodule

// File: tb/tb_march_bist_ctrl.sv
// tb_march_bist_ctrl: directed bench for march_bist_ctrl with behavioural SRAMs and stuck-at injection
module tb_march_bist_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  bg = 4'h0;
    logic        fault0 = 1'b0, fault1 = 1'b0;
    logic        busy0, done0, fail0, pass0, busy1, done1, fail1, pass1;
    logic [11:0] fc0, fc1;
    logic [7:0]  ffa0, ffa1;
    logic [2:0]  ffe0, ffe1;
    logic [3:0]  ffs0, ffs1;
    logic [3:0]  mem0 [256];
    logic [3:0]  mem1 [256];
    int          ops0 = 0, badw = 0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    march_bist_if #(.ADDR_W(8), .DATA_W(4)) s0();
    march_bist_if #(.ADDR_W(8), .DATA_W(4)) s1();

    march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1), .CNT_W(12), .STOP_ON_FAIL(0)) u0 (
        .Clock(clk), .Reset_n(rst_n), .Start(start0), .Mode(mode), .Background(bg), .sram(s0),
        .Busy(busy0), .Done(done0), .Fail(fail0), .Pass(pass0), .Fail_Count(fc0),
        .First_Fail_Addr(ffa0), .First_Fail_Elem(ffe0), .First_Fail_Syn(ffs0));

    march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1), .CNT_W(12), .STOP_ON_FAIL(1)) u1 (
        .Clock(clk), .Reset_n(rst_n), .Start(start1), .Mode(mode), .Background(bg), .sram(s1),
        .Busy(busy1), .Done(done1), .Fail(fail1), .Pass(pass1), .Fail_Count(fc1),
        .First_Fail_Addr(ffa1), .First_Fail_Elem(ffe1), .First_Fail_Syn(ffs1));

    // RD_LAT = 1 SRAMs; the fault forces bit 0 high on reads of 0x5A
    always @(posedge clk) begin
        if (s0.Sram_En) begin
            if (s0.Sram_WE) mem0[s0.Sram_Addr] <= s0.Sram_Wdata;
            else s0.Sram_Rdata <= mem0[s0.Sram_Addr] | {3'b000, fault0 && s0.Sram_Addr == 8'h5A};
        end
        if (s1.Sram_En) begin
            if (s1.Sram_WE) mem1[s1.Sram_Addr] <= s1.Sram_Wdata;
            else s1.Sram_Rdata <= mem1[s1.Sram_Addr] | {3'b000, fault1 && s1.Sram_Addr == 8'h5A};
        end
        if (s0.Sram_En) ops0 <= ops0 + 1;
        if (s0.Sram_En && s0.Sram_WE && !(s0.Sram_Wdata inside {4'hA, 4'h5})) badw <= badw + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n = edges after the Start edge until Done is seen (-1 on timeout);
    // fail_n = edge at which Fail was first seen, en_fail = Sram_En right then
    task automatic run(input bit sel, input int pulse_at, output int n, output int fail_n,
                       output logic en_fail, output logic [2:0] k_st);
        @(negedge clk);
        start0 = !sel;
        start1 = sel;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        k_st = sel ? {busy1, done1, fail1} : {busy0, done0, fail0};
        n = 0;
        fail_n = 0;
        en_fail = 1'bx;
        while (n < 5000) begin
            @(posedge clk);
            n++;
            #1;
            if (!sel) start0 = (n == pulse_at);
            if (fail_n == 0 && (sel ? fail1 : fail0)) begin
                fail_n = n;
                en_fail = sel ? s1.Sram_En : s0.Sram_En;
            end
            if (sel ? done1 : done0) break;
        end
        if (!(sel ? done1 : done0)) n = -1;
    endtask

    initial begin
        int n, fail_n, ops_a, bad_a;
        logic en_fail;
        logic [2:0] k_st;

        // reset
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ctrl0", {busy0, done0, fail0, pass0, s0.Sram_En, s0.Sram_WE}, 0);
        chk("rst_cnt0", fc0, 0);
        chk("rst_ff0", {ffa0, ffe0, ffs0}, 0);
        chk("rst_ctrl1", {busy1, done1, fail1, pass1, s1.Sram_En, fc1}, 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: fault-free March C-, background 0
        ops_a = ops0;
        run(0, 0, n, fail_n, en_fail, k_st);
        chk("t1_start_state", k_st, 3'b100);
        chk("t1_done_edge", n, 2562);
        chk("t1_pass", {pass0, fail0, busy0}, 3'b100);
        chk("t1_fail_count", fc0, 0);
        chk("t1_ops", ops0 - ops_a, 2560);

        // 2: bit0 stuck-at-1 at 0x5A
        fault0 = 1'b1;
        run(0, 0, n, fail_n, en_fail, k_st);
        chk("t2_done_edge", n, 2562);
        chk("t2_fail_edge", fail_n, 439);
        chk("t2_fail_pass", {fail0, pass0}, 2'b10);
        chk("t2_ff_addr", ffa0, 8'h5A);
        chk("t2_ff_elem", ffe0, 1);
        chk("t2_ff_syn", ffs0, 4'b0001);
        chk("t2_fail_count", fc0, 3);

        // 3: MATS+, background 1010, started from DONE with Fail set
        fault0 = 1'b0;
        mode = 1'b1;
        bg = 4'hA;
        ops_a = ops0;
        bad_a = badw;
        run(0, 0, n, fail_n, en_fail, k_st);
        chk("t3_start_clears", k_st, 3'b100);
        chk("t3_done_edge", n, 1282);
        chk("t3_pass", {pass0, fail0}, 2'b10);
        chk("t3_ops", ops0 - ops_a, 1280);
        chk("t3_bad_writes", badw - bad_a, 0);

        // 6: Start pulsed during the last busy cycle is ignored
        mode = 1'b0;
        bg = 4'h0;
        run(0, 2561, n, fail_n, en_fail, k_st);
        chk("t6_done_edge", n, 2562);
        @(posedge clk);
        #1;
        chk("t6_no_restart", {busy0, done0}, 2'b01);

        // 4: stop-on-fail engine with the same fault
        fault1 = 1'b1;
        run(1, 0, n, fail_n, en_fail, k_st);
        chk("t4_fail_edge", fail_n, 439);
        chk("t4_en_after_fail", en_fail, 0);
        chk("t4_done_edge", n, 441);
        chk("t4_fail_count", fc1, 1);
        chk("t4_ff_addr", ffa1, 8'h5A);
        chk("t4_pass", {pass1, fail1}, 2'b01);

        // 5: asynchronous reset mid-run, then a clean pass
        fault0 = 1'b1;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (1000) @(posedge clk);
        #2;
        chk("t5_mid_run", {busy0, fail0, fc0}, {2'b11, 12'd1});
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ctrl", {busy0, done0, fail0, pass0, s0.Sram_En, s0.Sram_WE}, 0);
        chk("t5_rst_stats", {fc0, ffa0, ffe0, ffs0}, 0);
        chk("t5_rst_bus", {s0.Sram_Addr, s0.Sram_Wdata}, 0);
        @(negedge clk) rst_n = 1'b1;
        fault0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stays_idle", {busy0, done0, s0.Sram_En}, 0);
        run(0, 0, n, fail_n, en_fail, k_st);
        chk("t5_done_edge", n, 2562);
        chk("t5_pass", {pass0, fail0, fc0}, {2'b10, 12'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
